vga_fb_reader: RTL and testbench

//  Downstream consumer of the camera capture path. Scans the frame buffer that the

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_fb_reader_if.sv | 29 ++
 rtl/vga_timing.sv | 52 +++++
 rtl/vga_fb_reader.sv | 103 ++++++++++
 tb/tb_vga_fb_reader.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA definitions for the frame-buffer display path.
//   - default 640x480@60 timing (clocks / lines) and their totals
//   - LAT: counter-to-pin latency of the reader pipeline
//   - rgb444_t / pix_flags_t typedefs
//   - rgb332_to_444(): bit-replicating colour expansion
package vga_pkg;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int H_TOT = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
  localparam int V_TOT = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

  localparam int LAT = 3;   // counters -> addr -> data -> rgb
  localparam int CW  = 10;  // h/v counter width

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Per-pixel side-band that travels alongside the memory read.
  typedef struct packed {
    logic hs_n;
    logic vs_n;
    logic vis;
    logic img;
    logic fs;
  } pix_flags_t;

  // MSB replication keeps full-scale white at 4'hF.
  function automatic rgb444_t rgb332_to_444(input logic [7:0] d);
    rgb444_t c;
    c.r = {d[7:5], d[7]};
    c.g = {d[4:2], d[4]};
    c.b = {d[1:0], d[1:0]};
    return c;
  endfunction

endpackage

// File: rtl/vga_fb_reader_if.sv
// vga_fb_reader_if: frame-buffer read port plus VGA pin bundle.
//   mem_px_addr  reader -> buffer  read address
//   mem_px_data  buffer -> reader  RGB332, valid 1 clk after the address
//   vga_hsync/vga_vsync            active-low syncs
//   vga_r/vga_g/vga_b              RGB444
//   frame_start                    1-clk pulse on pixel (0,0)
// master = the reader; slave = memory + display side.
interface vga_fb_reader_if #(
  parameter int AW = 15
);
  logic [AW-1:0] mem_px_addr;
  logic [7:0]    mem_px_data;
  logic          vga_hsync;
  logic          vga_vsync;
  logic [3:0]    vga_r;
  logic [3:0]    vga_g;
  logic [3:0]    vga_b;
  logic          frame_start;

  modport master (
    output mem_px_addr, vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_start,
    input  mem_px_data
  );

  modport slave (
    input  mem_px_addr, vga_hsync, vga_vsync, vga_r, vga_g, vga_b, frame_start,
    output mem_px_data
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster counters and undelayed timing flags.
//   clk, rst (async, active-low)
//   h_cnt/v_cnt   current raster position
//   h_last/v_last counters at their final value
//   vis           inside the visible area
//   hs_n/vs_n     raw active-low syncs (not yet aligned to any pipeline)
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS  = H_VIS_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_VIS  = V_VIS_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          h_last,
  output logic          v_last,
  output logic          vis,
  output logic          hs_n,
  output logic          vs_n
);

  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;

  assign h_last = (h_cnt == CW'(HT - 1));
  assign v_last = (v_cnt == CW'(VT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + CW'(1);
    end else begin
      h_cnt <= h_cnt + CW'(1);
    end
  end

  assign vis  = (h_cnt < CW'(H_VIS)) && (v_cnt < CW'(V_VIS));
  assign hs_n = !((h_cnt >= CW'(H_VIS + H_FP)) && (h_cnt < CW'(H_VIS + H_FP + H_SYNC)));
  assign vs_n = !((v_cnt >= CW'(V_VIS + V_FP)) && (v_cnt < CW'(V_VIS + V_FP + V_SYNC)));

endmodule

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: scans the capture frame buffer and drives VGA.
//   clk  25 MHz pixel clock
//   rst  async, active-low
//   bus  vga_fb_reader_if.master: mem_px_addr/mem_px_data read port,
//        vga_hsync/vga_vsync/vga_r/vga_g/vga_b/frame_start pins
// The IMG_W x IMG_H image sits top-left on a BG_COLOR background.
// Pin state at cycle T+LAT reflects raster position of cycle T.
// Build option: define VGA_SCALE2X_EN to show each stored pixel as 2x2.
module vga_fb_reader
  import vga_pkg::*;
#(
  parameter int         AW       = 15,
  parameter int         IMG_W    = 160,
  parameter int         IMG_H    = 120,
  parameter logic [7:0] BG_COLOR = 8'h00,
  parameter int         H_VIS    = H_VIS_DEF,
  parameter int         H_FP     = H_FP_DEF,
  parameter int         H_SYNC   = H_SYNC_DEF,
  parameter int         H_BP     = H_BP_DEF,
  parameter int         V_VIS    = V_VIS_DEF,
  parameter int         V_FP     = V_FP_DEF,
  parameter int         V_SYNC   = V_SYNC_DEF,
  parameter int         V_BP     = V_BP_DEF
) (
  input logic             clk,
  input logic             rst,
  vga_fb_reader_if.master bus
);

`ifdef VGA_SCALE2X_EN
  localparam int S_SH = 1;
`else
  localparam int S_SH = 0;
`endif

  localparam rgb444_t    BG_RGB    = rgb332_to_444(BG_COLOR);
  localparam pix_flags_t FLG_RESET = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0, img: 1'b0, fs: 1'b0};

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_last, v_last, vis, hs_n, vs_n, img;
  logic [AW-1:0] row_base, mem_addr;
  pix_flags_t    cur_flg;
  pix_flags_t [LAT:1] flg_pipe;
  rgb444_t       rgb;

  vga_timing #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_tim (
    .clk(clk), .rst(rst),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .h_last(h_last), .v_last(v_last),
    .vis(vis), .hs_n(hs_n), .vs_n(vs_n)
  );

  assign img = vis && (h_cnt < CW'(IMG_W << S_SH)) && (v_cnt < CW'(IMG_H << S_SH));

  // Line-start address tracked incrementally instead of v*IMG_W. Cleared on
  // the wrap into v=0 so the first line of every frame starts at 0; under
  // scaling it advances only after the second copy of each stored line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_base <= '0;
    end else if (h_last) begin
      if (v_last)
        row_base <= '0;
      else if ((v_cnt < CW'(IMG_H << S_SH)) && ((S_SH == 0) || v_cnt[0]))
        row_base <= row_base + AW'(IMG_W);
    end
  end

  // Stage 1: read address, parked at 0 outside the image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     mem_addr <= '0;
    else if (img) mem_addr <= row_base + AW'(h_cnt >> S_SH);
    else          mem_addr <= '0;
  end

  assign cur_flg = '{hs_n: hs_n, vs_n: vs_n, vis: vis, img: img,
                     fs: (h_cnt == '0) && (v_cnt == '0)};

  // Side-band delay matching the address/data/colour stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flg_pipe <= {LAT{FLG_RESET}};
    else      flg_pipe <= {flg_pipe[LAT-1:1], cur_flg};
  end

  // Stage 3: colour select, using flags that line up with returned data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      rgb <= '0;
    else if (flg_pipe[LAT-1].img)  rgb <= rgb332_to_444(bus.mem_px_data);
    else if (flg_pipe[LAT-1].vis)  rgb <= BG_RGB;
    else                           rgb <= '0;
  end

  assign bus.mem_px_addr = mem_addr;
  assign bus.vga_r       = rgb.r;
  assign bus.vga_g       = rgb.g;
  assign bus.vga_b       = rgb.b;
  assign bus.vga_hsync   = flg_pipe[LAT].hs_n;
  assign bus.vga_vsync   = flg_pipe[LAT].vs_n;
  assign bus.frame_start = flg_pipe[LAT].fs;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader. Horizontal/vertical timing is shrunk
// (216 clks x 140 lines) so two whole frames fit in a short run; the image
// geometry stays 160x120. n counts clk edges since the last reset release,
// so pins at step n show raster index n-3 and mem_px_addr shows index n-1.
module tb_vga_fb_reader;

  localparam int HV = 200, HFP = 4, HS = 8, HBP = 4;
  localparam int VV = 130, VFP = 3, VS = 2, VBP = 5;
  localparam int HT = HV + HFP + HS + HBP;          // 216
  localparam int VT = VV + VFP + VS + VBP;          // 140
  localparam int FRAME = HT * VT;                   // 30240
  localparam logic [7:0] BG = 8'hE5;                // expands to 12'hF25

  logic clk, rst;
  vga_fb_reader_if #(.AW(15)) bus ();

  vga_fb_reader #(
    .AW(15), .IMG_W(160), .IMG_H(120), .BG_COLOR(BG),
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Frame buffer model: data = addr[7:0], one clk read latency.
  always @(posedge clk) bus.mem_px_data <= bus.mem_px_addr[7:0];

  int errs = 0, checks = 0, n = 0;
  bit mon = 0;
  logic prev_hs, prev_vs;
  int hs_fall, vs_fall, hs_falls, vs_falls, fs_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rgb();
    return int'({bus.vga_r, bus.vga_g, bus.vga_b});
  endfunction

  // Event-driven timing checks on the output pins.
  task automatic monitor();
    if (prev_hs && !bus.vga_hsync) begin
      hs_fall = n; hs_falls++;
      chk("hs_fall_pos", (n - 3) % HT, HV + HFP);
    end
    if (!prev_hs && bus.vga_hsync && hs_falls > 0) chk("hs_width", n - hs_fall, HS);
    if (prev_vs && !bus.vga_vsync) begin
      vs_fall = n; vs_falls++;
      chk("vs_fall_pos", (n - 3) % FRAME, (VV + VFP) * HT);
    end
    if (!prev_vs && bus.vga_vsync && vs_falls > 0) chk("vs_width", n - vs_fall, VS * HT);
    if (bus.frame_start) begin
      fs_cnt++;
      chk("fs_pos", (n - 3) % FRAME, 0);
    end
    prev_hs = bus.vga_hsync;
    prev_vs = bus.vga_vsync;
  endtask

  task automatic step();
    @(posedge clk); #1;
    n++;
    if (mon) monitor();
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_rgb"}, rgb(), 0);
    chk({tag, "_hs"}, int'(bus.vga_hsync), 1);
    chk({tag, "_vs"}, int'(bus.vga_vsync), 1);
    chk({tag, "_fs"}, int'(bus.frame_start), 0);
    chk({tag, "_addr"}, int'(bus.mem_px_addr), 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_pins("por");
    @(negedge clk) rst = 1'b1;
    n = 0;

    // Run into line 3, then reset mid-line with h=100 on the counters.
    run_to(748);
`ifdef VGA_SCALE2X_EN
    chk("pre_rst_px97_3", rgb(), 'hD90);
`else
    chk("pre_rst_px97_3", rgb(), 'h405);
`endif
    rst = 1'b0;
    #1 chk_reset_pins("rst_async");
    repeat (3) begin
      @(posedge clk); #1;
      chk_reset_pins("rst_hold");
      chk("rst_hcnt", int'(dut.u_tim.h_cnt), 0);
    end
    @(negedge clk) rst = 1'b1;
    n = 0;
    chk("rel_hcnt", int'(dut.u_tim.h_cnt), 0);
    chk("rel_vcnt", int'(dut.u_tim.v_cnt), 0);

    prev_hs = 1'b1; prev_vs = 1'b1;
    hs_falls = 0; vs_falls = 0; fs_cnt = 0; hs_fall = 0; vs_fall = 0;
    mon = 1;

`ifdef VGA_SCALE2X_EN
    run_to(3);      chk("fs_first", int'(bus.frame_start), 1);
                    chk("addr_2_0", int'(bus.mem_px_addr), 1);
    run_to(4);      chk("addr_3_0", int'(bus.mem_px_addr), 1);
    run_to(8);      chk("rgb_5_0", rgb(), 'h00A);
    run_to(163);    chk("rgb_160_0", rgb(), 'h490);
    run_to(208);    chk("rgb_blank_205", rgb(), 0);
                    chk("hs_low_205", int'(bus.vga_hsync), 0);
    run_to(219);    chk("addr_2_1", int'(bus.mem_px_addr), 1);
    run_to(220);    chk("addr_3_1", int'(bus.mem_px_addr), 1);
    run_to(435);    chk("rgb_0_2", rgb(), 'hB00);
    run_to(30242);  chk("f2_addr_1_0", int'(bus.mem_px_addr), 0);
    run_to(30675);  chk("f2_addr_2_2", int'(bus.mem_px_addr), 161);
`else
    run_to(3);      chk("fs_first", int'(bus.frame_start), 1);
    run_to(6);      chk("addr_5_0", int'(bus.mem_px_addr), 5);
    run_to(8);      chk("rgb_5_0", rgb(), 'h025);
    run_to(161);    chk("addr_160_0", int'(bus.mem_px_addr), 0);
    run_to(163);    chk("rgb_160_0_bg", rgb(), 'hF25);
    run_to(208);    chk("rgb_blank_205", rgb(), 0);
                    chk("hs_low_205", int'(bus.vga_hsync), 0);
    run_to(219);    chk("rgb_0_1", rgb(), 'hB00);
    run_to(438);    chk("rgb_3_2", rgb(), 'h40F);
    run_to(25864);  chk("addr_last_px", int'(bus.mem_px_addr), 19199);
    run_to(25923);  chk("rgb_0_120_bg", rgb(), 'hF25);
    run_to(30241);  chk("f2_addr_0_0", int'(bus.mem_px_addr), 0);
    run_to(30242);  chk("f2_addr_1_0", int'(bus.mem_px_addr), 1);
    run_to(30458);  chk("f2_addr_1_1", int'(bus.mem_px_addr), 161);
`endif

    run_to(2 * FRAME + 10);
    chk("fs_count", fs_cnt, 3);
    chk("hs_fall_count", hs_falls, 280);
    chk("vs_fall_count", vs_falls, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
